// File: rtl/sfp_link_pkg.sv
// rtl/sfp_link_pkg.sv - shared constants and state encodings for the SFP frame link
package sfp_link_pkg;

    localparam logic [15:0] SYNC        = 16'hA55A;
    localparam int          FRAME_WORDS = 4;
    localparam logic [31:0] CRC_POLY    = 32'h04C1_1DB7;
    localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_HDR,
        TX_DATA,
        TX_CRC,
        TX_DONE
    } tx_state_e;

    typedef enum logic [1:0] {
        RX_HUNT,
        RX_DATA,
        RX_CRC
    } rx_state_e;

endpackage

// File: rtl/sfp_frame_link_if.sv
// rtl/sfp_frame_link_if.sv - 32-bit word stream bundle with producer/consumer views
interface sfp_frame_link_if #(
    parameter int W = 32
);
    logic [W-1:0] tdata;
    logic         tvalid;
    logic         tready;
    logic         tlast;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/sfp_crc32_word.sv
// rtl/sfp_crc32_word.sv - one 32-bit word step of CRC-32 (poly 04C11DB7, MSB first, unreflected)
module sfp_crc32_word
    import sfp_link_pkg::*;
(
    input  logic [31:0] crc_i,
    input  logic [31:0] data_i,
    output logic [31:0] crc_o
);

    logic [31:0] crc_v;

    always_comb begin
        crc_v = crc_i;
        for (int i = 31; i >= 0; i--) begin
            if (crc_v[31] ^ data_i[i]) begin
                crc_v = {crc_v[30:0], 1'b0} ^ CRC_POLY;
            end else begin
                crc_v = {crc_v[30:0], 1'b0};
            end
        end
        crc_o = crc_v;
    end

endmodule

// File: rtl/sfp_frame_link_rx.sv
// rtl/sfp_frame_link_rx.sv - RX parser: sync hunt, 4 data words, CRC/length checks, counters
module sfp_frame_link_rx
    import sfp_link_pkg::*;
#(
    parameter int C_DATA_FRAME_BIT = 128,
    parameter int C_LANE_WIDTH     = 32,
    parameter int C_RX_TIMEOUT     = 64
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    sfp_frame_link_if.slave             s_axis,
    output logic [C_DATA_FRAME_BIT-1:0] rx_frame_o,
    output logic                        end_flag_o,
    output logic                        crc_err_o,
    output logic                        len_err_o,
    output logic [15:0]                 frame_cnt_o,
    output logic [15:0]                 err_cnt_o
);

    localparam int TW = $clog2(C_RX_TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(C_RX_TIMEOUT - 1);

    rx_state_e                   state_q, state_d;
    logic [1:0]                  cnt_q, cnt_d;
    logic [31:0]                 crc_q, crc_d;
    logic [C_DATA_FRAME_BIT-1:0] buf_q, buf_d;
    logic [C_DATA_FRAME_BIT-1:0] frame_q, frame_d;
    logic [TW-1:0]               tmo_q, tmo_d;
    logic                        end_q, end_d;
    logic                        crc_err_q, crc_err_d;
    logic                        len_err_q, len_err_d;
    logic [15:0]                 fcnt_q, fcnt_d;
    logic [15:0]                 ecnt_q, ecnt_d;
    logic [31:0]                 crc_in;
    logic [31:0]                 crc_nxt;

    // The sync word always seeds the CRC from the init value.
    assign crc_in = (state_q == RX_HUNT) ? CRC_INIT : crc_q;

    sfp_crc32_word u_crc (
        .crc_i  (crc_in),
        .data_i (s_axis.tdata),
        .crc_o  (crc_nxt)
    );

    assign s_axis.tready = 1'b1;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        crc_d     = crc_q;
        buf_d     = buf_q;
        frame_d   = frame_q;
        tmo_d     = tmo_q;
        end_d     = 1'b0;
        crc_err_d = 1'b0;
        len_err_d = 1'b0;
        fcnt_d    = fcnt_q;
        ecnt_d    = ecnt_q;

        if (s_axis.tvalid) begin
            tmo_d = '0;
            case (state_q)
                RX_HUNT: begin
                    if (s_axis.tdata[31:16] == SYNC) begin
                        if (s_axis.tlast) begin
                            len_err_d = 1'b1;
                        end else begin
                            crc_d   = crc_nxt;
                            cnt_d   = 2'd0;
                            state_d = RX_DATA;
                        end
                    end
                end
                RX_DATA: begin
                    if (s_axis.tlast) begin
                        len_err_d = 1'b1;
                        state_d   = RX_HUNT;
                    end else begin
                        buf_d = {buf_q[C_DATA_FRAME_BIT-C_LANE_WIDTH-1:0], s_axis.tdata};
                        crc_d = crc_nxt;
                        cnt_d = cnt_q + 2'd1;
                        if (cnt_q == 2'(FRAME_WORDS - 1)) begin
                            state_d = RX_CRC;
                        end
                    end
                end
                RX_CRC: begin
                    state_d = RX_HUNT;
                    if (!s_axis.tlast) begin
                        len_err_d = 1'b1;
                    end else if (s_axis.tdata == crc_q) begin
                        frame_d = buf_q;
                        end_d   = 1'b1;
                        if (fcnt_q != 16'hFFFF) begin
                            fcnt_d = fcnt_q + 16'd1;
                        end
                    end else begin
                        crc_err_d = 1'b1;
                    end
                end
                default: state_d = RX_HUNT;
            endcase
        end else if (state_q != RX_HUNT) begin
            if (tmo_q == TMO_LAST) begin
                len_err_d = 1'b1;
                tmo_d     = '0;
                state_d   = RX_HUNT;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end

        if ((crc_err_d || len_err_d) && (ecnt_q != 16'hFFFF)) begin
            ecnt_d = ecnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= RX_HUNT;
            cnt_q     <= '0;
            crc_q     <= '0;
            buf_q     <= '0;
            frame_q   <= '0;
            tmo_q     <= '0;
            end_q     <= 1'b0;
            crc_err_q <= 1'b0;
            len_err_q <= 1'b0;
            fcnt_q    <= '0;
            ecnt_q    <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            crc_q     <= crc_d;
            buf_q     <= buf_d;
            frame_q   <= frame_d;
            tmo_q     <= tmo_d;
            end_q     <= end_d;
            crc_err_q <= crc_err_d;
            len_err_q <= len_err_d;
            fcnt_q    <= fcnt_d;
            ecnt_q    <= ecnt_d;
        end
    end

    assign rx_frame_o  = frame_q;
    assign end_flag_o  = end_q;
    assign crc_err_o   = crc_err_q;
    assign len_err_o   = len_err_q;
    assign frame_cnt_o = fcnt_q;
    assign err_cnt_o   = ecnt_q;

endmodule

// File: rtl/sfp_frame_link.sv
// rtl/sfp_frame_link.sv - SFP link end: TX frame serialiser plus independent RX parser
module sfp_frame_link
    import sfp_link_pkg::*;
#(
    parameter int C_DATA_FRAME_BIT = 128,
    parameter int C_LANE_WIDTH     = 32,
    parameter int C_RX_TIMEOUT     = 64
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_sfp_start_flag,
    input  logic [C_DATA_FRAME_BIT-1:0] i_tx_frame,
    output logic                        o_tx_en,
    output logic                        o_tx_busy,
    output logic                        o_tx_drop,
    sfp_frame_link_if.master            m_axis,
    sfp_frame_link_if.slave             s_axis,
    output logic [C_DATA_FRAME_BIT-1:0] o_rx_frame,
    output logic                        o_sfp_end_flag,
    output logic                        o_rx_crc_err,
    output logic                        o_rx_len_err,
    output logic [15:0]                 o_rx_frame_cnt,
    output logic [15:0]                 o_rx_err_cnt
);

    tx_state_e                   state_q, state_d;
    logic [C_DATA_FRAME_BIT-1:0] frame_q, frame_d;
    logic [7:0]                  seq_q, seq_d;
    logic [1:0]                  cnt_q, cnt_d;
    logic [31:0]                 crc_q, crc_d;
    logic                        drop_q, drop_d;
    logic [C_LANE_WIDTH-1:0]     tx_tdata;
    logic                        tx_tvalid;
    logic                        tx_tlast;
    logic [31:0]                 crc_nxt;

    // Stream outputs decode only the registered state so they never depend on tready.
    always_comb begin
        tx_tvalid = 1'b0;
        tx_tlast  = 1'b0;
        tx_tdata  = '0;
        case (state_q)
            TX_HDR: begin
                tx_tvalid = 1'b1;
                tx_tdata  = {SYNC, seq_q, 8'h00};
            end
            TX_DATA: begin
                tx_tvalid = 1'b1;
                case (cnt_q)
                    2'd0:    tx_tdata = frame_q[127:96];
                    2'd1:    tx_tdata = frame_q[95:64];
                    2'd2:    tx_tdata = frame_q[63:32];
                    default: tx_tdata = frame_q[31:0];
                endcase
            end
            TX_CRC: begin
                tx_tvalid = 1'b1;
                tx_tlast  = 1'b1;
                tx_tdata  = crc_q;
            end
            default: ;
        endcase
    end

    sfp_crc32_word u_tx_crc (
        .crc_i  (crc_q),
        .data_i (tx_tdata),
        .crc_o  (crc_nxt)
    );

    always_comb begin
        state_d = state_q;
        frame_d = frame_q;
        seq_d   = seq_q;
        cnt_d   = cnt_q;
        crc_d   = crc_q;
        drop_d  = i_sfp_start_flag && (state_q != TX_IDLE);

        case (state_q)
            TX_IDLE: begin
                if (i_sfp_start_flag) begin
                    frame_d = i_tx_frame;
                    crc_d   = CRC_INIT;
                    cnt_d   = 2'd0;
                    state_d = TX_HDR;
                end
            end
            TX_HDR: begin
                if (m_axis.tready) begin
                    crc_d   = crc_nxt;
                    state_d = TX_DATA;
                end
            end
            TX_DATA: begin
                if (m_axis.tready) begin
                    crc_d = crc_nxt;
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'(FRAME_WORDS - 1)) begin
                        state_d = TX_CRC;
                    end
                end
            end
            TX_CRC: begin
                if (m_axis.tready) begin
                    state_d = TX_DONE;
                end
            end
            TX_DONE: begin
                seq_d   = seq_q + 8'd1;
                state_d = TX_IDLE;
            end
            default: state_d = TX_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= TX_IDLE;
            frame_q <= '0;
            seq_q   <= '0;
            cnt_q   <= '0;
            crc_q   <= '0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            frame_q <= frame_d;
            seq_q   <= seq_d;
            cnt_q   <= cnt_d;
            crc_q   <= crc_d;
            drop_q  <= drop_d;
        end
    end

    assign m_axis.tdata  = tx_tdata;
    assign m_axis.tvalid = tx_tvalid;
    assign m_axis.tlast  = tx_tlast;
    assign o_tx_en       = (state_q == TX_DONE);
    assign o_tx_busy     = (state_q != TX_IDLE);
    assign o_tx_drop     = drop_q;

    sfp_frame_link_rx #(
        .C_DATA_FRAME_BIT (C_DATA_FRAME_BIT),
        .C_LANE_WIDTH     (C_LANE_WIDTH),
        .C_RX_TIMEOUT     (C_RX_TIMEOUT)
    ) u_rx (
        .clk_i       (i_clk),
        .rst_i       (i_rst),
        .s_axis      (s_axis),
        .rx_frame_o  (o_rx_frame),
        .end_flag_o  (o_sfp_end_flag),
        .crc_err_o   (o_rx_crc_err),
        .len_err_o   (o_rx_len_err),
        .frame_cnt_o (o_rx_frame_cnt),
        .err_cnt_o   (o_rx_err_cnt)
    );

endmodule

// File: tb/tb_sfp_frame_link.sv
// tb/tb_sfp_frame_link.sv - directed self-checking bench for sfp_frame_link
module tb_sfp_frame_link;

    localparam logic [127:0] F0 = 128'h0000_1111_0001_0000_1234_5678_9ABC_DEF0;
    localparam logic [127:0] F1 = 128'hCAFE_BABE_0102_0304_A0B0_C0D0_1122_3344;
    localparam logic [127:0] F2 = 128'h7777_0000_FFFF_0001_8000_0000_0000_0001;
    localparam logic [127:0] F3 = 128'h0BAD_F00D_1357_9BDF_2468_ACE0_5555_AAAA;
    localparam logic [127:0] F4 = 128'h0F0F_0F0F_F0F0_F0F0_3C3C_3C3C_C3C3_C3C3;
    localparam logic [127:0] F5 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;

    logic         clk;
    logic         rst;
    logic         start;
    logic [127:0] tx_frame;
    logic         tx_en, tx_busy, tx_drop;
    logic [127:0] rx_frame;
    logic         end_flag, crc_err, len_err;
    logic [15:0]  fcnt, ecnt;
    logic         tx_tready;
    logic         loop_en;
    logic         rx_tvalid, rx_tlast;
    logic [31:0]  rx_tdata;
    int           n_cmp;
    int           n_bad;

    sfp_frame_link_if m_if ();
    sfp_frame_link_if s_if ();

    assign m_if.tready = tx_tready;
    assign s_if.tdata  = loop_en ? m_if.tdata : rx_tdata;
    assign s_if.tvalid = loop_en ? (m_if.tvalid & m_if.tready) : rx_tvalid;
    assign s_if.tlast  = loop_en ? m_if.tlast : rx_tlast;

    sfp_frame_link dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_sfp_start_flag (start),
        .i_tx_frame       (tx_frame),
        .o_tx_en          (tx_en),
        .o_tx_busy        (tx_busy),
        .o_tx_drop        (tx_drop),
        .m_axis           (m_if),
        .s_axis           (s_if),
        .o_rx_frame       (rx_frame),
        .o_sfp_end_flag   (end_flag),
        .o_rx_crc_err     (crc_err),
        .o_rx_len_err     (len_err),
        .o_rx_frame_cnt   (fcnt),
        .o_rx_err_cnt     (ecnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [31:0] crc_model(input logic [159:0] bits);
        logic [31:0] c;
        c = 32'hFFFF_FFFF;
        for (int i = 159; i >= 0; i--) begin
            c = (c[31] ^ bits[i]) ? ({c[30:0], 1'b0} ^ 32'h04C1_1DB7) : {c[30:0], 1'b0};
        end
        return c;
    endfunction

    function automatic logic [191:0] mk_pkt(input logic [127:0] f, input logic [7:0] seq);
        logic [159:0] body;
        body = {16'hA55A, seq, 8'h00, f};
        return {body, crc_model(body)};
    endfunction

    function automatic logic [31:0] pkt_word(input logic [191:0] p, input int i);
        return p[191-32*i -: 32];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rx_drive(input logic [191:0] p, input logic [5:0] lastm, input int n);
        for (int i = 0; i < n; i++) begin
            rx_tvalid = 1'b1;
            rx_tdata  = pkt_word(p, i);
            rx_tlast  = lastm[i];
            step();
        end
        rx_tvalid = 1'b0;
        rx_tlast  = 1'b0;
        rx_tdata  = '0;
    endtask

    task automatic tx_send(input logic [127:0] f, output logic [31:0] w0,
                           output bit ok, output bit end_ok);
        int last_c;
        int end_c;
        bit got_w0;
        ok = 1'b0; last_c = -10; end_c = -20; got_w0 = 1'b0; w0 = '0;
        tx_frame = f;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            if (m_if.tvalid && m_if.tready && !got_w0) begin
                w0 = m_if.tdata;
                got_w0 = 1'b1;
            end
            if (m_if.tvalid && m_if.tready && m_if.tlast) last_c = c;
            if (end_flag) end_c = c;
            if (tx_en) begin
                ok = 1'b1;
                step();
                break;
            end
            step();
        end
        end_ok = (end_c == last_c + 1);
    endtask

    task automatic test_reset();
        logic [199:0] outs;
        rst = 1'b1;
        step();
        step();
        outs = {m_if.tvalid, m_if.tlast, m_if.tdata, tx_en, tx_busy, tx_drop,
                end_flag, crc_err, len_err, fcnt, ecnt, rx_frame};
        n_cmp++;
        if (outs !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %h want 0", outs);
        end
        rst = 1'b0;
        step();
        n_cmp++;
        if ({m_if.tvalid, tx_busy} !== 2'b00) begin
            n_bad++;
            $display("FAIL reset_idle: got %b want 00", {m_if.tvalid, tx_busy});
        end
    endtask

    task automatic test_tx_basic();
        logic [191:0] pkt;
        pkt = mk_pkt(F0, 8'd0);
        tx_tready = 1'b1;
        tx_frame = F0;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            n_cmp++;
            if (c <= 6) begin
                if ({m_if.tvalid, m_if.tlast, m_if.tdata, tx_en, tx_busy} !==
                    {1'b1, (c == 6), pkt_word(pkt, c - 1), 1'b0, 1'b1}) begin
                    n_bad++;
                    $display("FAIL tx_word%0d: got v=%b l=%b d=%h en=%b busy=%b want d=%h",
                             c - 1, m_if.tvalid, m_if.tlast, m_if.tdata, tx_en, tx_busy,
                             pkt_word(pkt, c - 1));
                end
            end else if (c == 7) begin
                if ({m_if.tvalid, tx_en, tx_busy} !== 3'b011) begin
                    n_bad++;
                    $display("FAIL tx_en_n7: got %b want 011", {m_if.tvalid, tx_en, tx_busy});
                end
            end else begin
                if ({m_if.tvalid, tx_en, tx_busy} !== 3'b000) begin
                    n_bad++;
                    $display("FAIL tx_idle_n8: got %b want 000", {m_if.tvalid, tx_en, tx_busy});
                end
            end
            step();
        end
    endtask

    task automatic test_tx_stall();
        logic [191:0] pkt;
        logic [31:0]  prev_data;
        logic         prev_last;
        bit           prev_stall;
        int           xfers, done_c, en_cnt, drop_cnt;
        pkt = mk_pkt(F0, 8'd1);
        prev_stall = 1'b0; prev_data = '0; prev_last = 1'b0;
        xfers = 0; done_c = -10; en_cnt = 0; drop_cnt = 0;
        tx_tready = 1'b1;
        tx_frame = F0;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            tx_tready = (cyc % 2 == 0);
            start = (cyc == 5);
            tx_frame = (cyc == 5) ? F1 : F0;
            if (prev_stall) begin
                n_cmp++;
                if ({m_if.tvalid, m_if.tlast, m_if.tdata} !== {1'b1, prev_last, prev_data}) begin
                    n_bad++;
                    $display("FAIL stall_stable c%0d: got v=%b l=%b d=%h want d=%h",
                             cyc, m_if.tvalid, m_if.tlast, m_if.tdata, prev_data);
                end
            end
            if (m_if.tvalid && tx_tready) begin
                n_cmp++;
                if (xfers > 5 || {m_if.tlast, m_if.tdata} !== {(xfers == 5), pkt_word(pkt, xfers)}) begin
                    n_bad++;
                    $display("FAIL stall_word%0d: got l=%b d=%h", xfers, m_if.tlast, m_if.tdata);
                end
                if (xfers == 5) done_c = cyc;
                xfers++;
            end
            if (tx_drop) drop_cnt++;
            if (cyc == 6) begin
                n_cmp++;
                if (tx_drop !== 1'b1) begin
                    n_bad++;
                    $display("FAIL tx_drop_pulse: got %b want 1", tx_drop);
                end
            end
            if (tx_en) begin
                en_cnt++;
                n_cmp++;
                if (cyc != done_c + 1) begin
                    n_bad++;
                    $display("FAIL stall_tx_en_time: got cycle %0d want %0d", cyc, done_c + 1);
                end
            end
            prev_stall = m_if.tvalid && !tx_tready;
            prev_data  = m_if.tdata;
            prev_last  = m_if.tlast;
            step();
        end
        start = 1'b0;
        tx_frame = F0;
        tx_tready = 1'b1;
        n_cmp++;
        if ({xfers, en_cnt, drop_cnt} !== {32'd6, 32'd1, 32'd1}) begin
            n_bad++;
            $display("FAIL stall_totals: got xfers=%0d en=%0d drop=%0d want 6 1 1",
                     xfers, en_cnt, drop_cnt);
        end
    endtask

    task automatic test_loopback();
        logic [31:0] w0;
        bit ok, end_ok;
        int bad_wrap;
        loop_en = 1'b1;
        tx_tready = 1'b1;
        tx_send(F1, w0, ok, end_ok);
        n_cmp++;
        if ({ok, end_ok, w0} !== {1'b1, 1'b1, 32'hA55A_0200}) begin
            n_bad++;
            $display("FAIL loop_first: got ok=%b end_ok=%b w0=%h want 1 1 a55a0200", ok, end_ok, w0);
        end
        n_cmp++;
        if ({rx_frame, fcnt} !== {F1, 16'd1}) begin
            n_bad++;
            $display("FAIL loop_rx_frame: got %h cnt=%0d want %h cnt=1", rx_frame, fcnt, F1);
        end
        bad_wrap = 0;
        for (int k = 3; k < 256; k++) begin
            tx_send(F1 ^ {4{32'(k)}}, w0, ok, end_ok);
            if (!ok || !end_ok || w0 !== {16'hA55A, 8'(k), 8'h00} || rx_frame !== (F1 ^ {4{32'(k)}}))
                bad_wrap++;
        end
        n_cmp++;
        if (bad_wrap != 0 || fcnt !== 16'd254) begin
            n_bad++;
            $display("FAIL loop_many: got bad=%0d cnt=%0d want 0 254", bad_wrap, fcnt);
        end
        tx_send(F2, w0, ok, end_ok);
        n_cmp++;
        if ({ok, end_ok, w0, fcnt, rx_frame} !== {1'b1, 1'b1, 32'hA55A_0000, 16'd255, F2}) begin
            n_bad++;
            $display("FAIL seq_wrap: got w0=%h cnt=%0d frame=%h want a55a0000 255 %h",
                     w0, fcnt, rx_frame, F2);
        end
        loop_en = 1'b0;
    endtask

    task automatic test_crc_err();
        logic [191:0] pkt;
        pkt = mk_pkt(F3, 8'h01);
        pkt[64] = ~pkt[64];
        rx_drive(pkt, 6'b10_0000, 6);
        n_cmp++;
        if ({crc_err, len_err, end_flag, ecnt, fcnt, rx_frame} !==
            {3'b100, 16'd1, 16'd255, F2}) begin
            n_bad++;
            $display("FAIL crc_err: got c=%b l=%b e=%b ecnt=%0d fcnt=%0d frame=%h",
                     crc_err, len_err, end_flag, ecnt, fcnt, rx_frame);
        end
        step();
        n_cmp++;
        if (crc_err !== 1'b0) begin
            n_bad++;
            $display("FAIL crc_err_width: got %b want 0", crc_err);
        end
        rx_tvalid = 1'b1;
        rx_tdata  = 32'h1234_0000;
        step();
        rx_tvalid = 1'b0;
        rx_tdata  = '0;
        step();
        n_cmp++;
        if ({crc_err, len_err, end_flag, ecnt} !== {3'b000, 16'd1}) begin
            n_bad++;
            $display("FAIL junk_word: got c=%b l=%b e=%b ecnt=%0d want 000 1",
                     crc_err, len_err, end_flag, ecnt);
        end
    endtask

    task automatic test_len_err();
        logic [191:0] pkt;
        int early;
        pkt = mk_pkt(F4, 8'h02);
        rx_drive(pkt, 6'b00_0100, 3);
        n_cmp++;
        if ({len_err, crc_err, end_flag, ecnt} !== {3'b100, 16'd2}) begin
            n_bad++;
            $display("FAIL len_tlast_w2: got l=%b c=%b e=%b ecnt=%0d want 100 2",
                     len_err, crc_err, end_flag, ecnt);
        end
        rx_drive(pkt, 6'b00_0000, 3);
        early = 0;
        for (int i = 1; i <= 64; i++) begin
            step();
            if (i < 64) begin
                if (len_err) early++;
            end else begin
                n_cmp++;
                if ({len_err, ecnt} !== {1'b1, 16'd3}) begin
                    n_bad++;
                    $display("FAIL len_timeout: got l=%b ecnt=%0d want 1 3", len_err, ecnt);
                end
            end
        end
        n_cmp++;
        if (early != 0) begin
            n_bad++;
            $display("FAIL len_timeout_early: got %0d pulses want 0", early);
        end
        rx_drive(pkt, 6'b10_0000, 6);
        n_cmp++;
        if ({end_flag, len_err, crc_err, rx_frame, fcnt, ecnt} !== {3'b100, F4, 16'd256, 16'd3}) begin
            n_bad++;
            $display("FAIL len_recover: got e=%b frame=%h fcnt=%0d ecnt=%0d",
                     end_flag, rx_frame, fcnt, ecnt);
        end
    endtask

    task automatic test_reset_mid();
        logic [191:0] pkt;
        logic [199:0] outs;
        logic [31:0]  w0;
        bit ok, end_ok;
        pkt = mk_pkt(F5, 8'h07);
        tx_tready = 1'b1;
        tx_frame = F5;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rx_tvalid = 1'b1;
            rx_tdata  = pkt_word(pkt, i);
            step();
        end
        n_cmp++;
        if (m_if.tdata !== F5[63:32]) begin
            n_bad++;
            $display("FAIL mid_tx_w3: got %h want %h", m_if.tdata, F5[63:32]);
        end
        rx_tdata = pkt_word(pkt, 3);
        rst = 1'b1;
        step();
        rst = 1'b0;
        rx_tvalid = 1'b0;
        rx_tdata = '0;
        outs = {m_if.tvalid, m_if.tlast, m_if.tdata, tx_en, tx_busy, tx_drop,
                end_flag, crc_err, len_err, fcnt, ecnt, rx_frame};
        n_cmp++;
        if (outs !== '0) begin
            n_bad++;
            $display("FAIL mid_reset_outputs: got %h want 0", outs);
        end
        loop_en = 1'b1;
        tx_send(F5, w0, ok, end_ok);
        loop_en = 1'b0;
        n_cmp++;
        if ({ok, end_ok, w0, rx_frame, fcnt, ecnt} !==
            {1'b1, 1'b1, 32'hA55A_0000, F5, 16'd1, 16'd0}) begin
            n_bad++;
            $display("FAIL post_reset_frame: got w0=%h frame=%h fcnt=%0d ecnt=%0d",
                     w0, rx_frame, fcnt, ecnt);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b1;
        start = 1'b0;
        tx_frame = '0;
        tx_tready = 1'b1;
        loop_en = 1'b0;
        rx_tvalid = 1'b0;
        rx_tlast = 1'b0;
        rx_tdata = '0;
        test_reset();
        test_tx_basic();
        test_tx_stall();
        test_loopback();
        test_crc_err();
        test_len_err();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
